// File: rtl/store_unit_pkg.sv
// Shared CPU package: store width encodings, data-bus address map and
// target-select encodings, plus a window-membership helper used by the
// address checkers on both the load and store sides.
package store_unit_pkg;

  // Store/load width field (BEop)
  typedef enum logic [1:0] {
    BE_SW  = 2'b00,
    BE_SH  = 2'b01,
    BE_SB  = 2'b10,
    BE_RSV = 2'b11
  } beop_e;

  // Data-bus target select
  typedef enum logic [1:0] {
    SEL_DM = 2'b00,
    SEL_T0 = 2'b01,
    SEL_T1 = 2'b10,
    SEL_IG = 2'b11
  } bus_sel_e;

  // Address map, identical to the one the load unit decodes
  localparam logic [31:0] DM_TOP_DEF   = 32'h0000_2fff;
  localparam logic [31:0] T0_BASE_DEF  = 32'h0000_7f00;
  localparam logic [31:0] T1_BASE_DEF  = 32'h0000_7f10;
  localparam logic [31:0] IG_BASE_DEF  = 32'h0000_7f20;
  localparam logic [31:0] T_WIN_BYTES  = 32'd12;
  localparam logic [31:0] IG_WIN_BYTES = 32'd4;
  // COUNT register occupies the last word of each timer window
  localparam logic [31:0] T_COUNT_OFS  = 32'd8;
  localparam logic [31:0] T_COUNT_LEN  = 32'd4;

  // True when base <= addr < base+len, evaluated on the full 32-bit address.
  // The lower-bound test comes first so the subtraction never wraps.
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] len);
    return (addr >= base) && ((addr - base) < len);
  endfunction

endpackage

// File: rtl/store_addr_check.sv
// Combinational address legality and target decode for a data-bus access.
// is_write_i gates the write-only rule (read-only timer COUNT registers), so
// the same block can serve the load-side legality check.
module store_addr_check
  import store_unit_pkg::*;
#(
  parameter logic [31:0] DM_TOP  = DM_TOP_DEF,
  parameter logic [31:0] T0_BASE = T0_BASE_DEF,
  parameter logic [31:0] T1_BASE = T1_BASE_DEF,
  parameter logic [31:0] IG_BASE = IG_BASE_DEF
) (
  input  logic [31:0] addr_i,
  input  logic [1:0]  beop_i,
  input  logic        ov_i,
  input  logic        is_write_i,
  output logic        addr_err_o,
  output logic [1:0]  sel_o
);

  logic in_dm, in_t0, in_t1, in_ig, in_cnt;
  logic misalign, sub_word_timer;

  // Region and alignment decode
  always_comb begin
    in_dm  = (addr_i <= DM_TOP);
    in_t0  = in_window(addr_i, T0_BASE, T_WIN_BYTES);
    in_t1  = in_window(addr_i, T1_BASE, T_WIN_BYTES);
    in_ig  = in_window(addr_i, IG_BASE, IG_WIN_BYTES);
    in_cnt = in_window(addr_i, T0_BASE + T_COUNT_OFS, T_COUNT_LEN) |
             in_window(addr_i, T1_BASE + T_COUNT_OFS, T_COUNT_LEN);

    misalign = 1'b0;
    case (beop_i)
      BE_SW:   misalign = (addr_i[1:0] != 2'b00);
      BE_SH:   misalign = addr_i[0];
      default: misalign = 1'b0;
    endcase

    // Timers only implement full-word access
    sub_word_timer = ((beop_i == BE_SH) || (beop_i == BE_SB)) && (in_t0 || in_t1);

    addr_err_o = misalign | sub_word_timer | (is_write_i & in_cnt) | ov_i |
                 !(in_dm | in_t0 | in_t1 | in_ig);
  end

  // Target select; an illegal address falls back to DM but is never used
  always_comb begin
    sel_o = SEL_DM;
    if (in_t0)      sel_o = SEL_T0;
    else if (in_t1) sel_o = SEL_T1;
    else if (in_ig) sel_o = SEL_IG;
  end

endmodule

// File: rtl/store_unit.sv
// M-stage store unit: byte-enable and lane-replicated data generation, AdES
// detection, and a one-entry write buffer driving the shared data bus with a
// valid/ready handshake. The M stage stalls only when the buffer is full and
// the bus does not accept this cycle.
module store_unit
  import store_unit_pkg::*;
#(
  parameter logic [31:0] DM_TOP  = DM_TOP_DEF,
  parameter logic [31:0] T0_BASE = T0_BASE_DEF,
  parameter logic [31:0] T1_BASE = T1_BASE_DEF,
  parameter logic [31:0] IG_BASE = IG_BASE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_valid,
  input  logic        store,
  input  logic [1:0]  BEop,
  input  logic [31:0] A,
  input  logic [31:0] Din,
  input  logic        DM_Ov,
  input  logic        flush,
  input  logic        bus_ready,
  output logic        Exc_AdES_M,
  output logic        stall_M,
  output logic        bus_wr_valid,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_byteen,
  output logic [1:0]  bus_sel
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} buf_state_e;

  buf_state_e  state_q;
  logic [31:0] addr_q, wdata_q, wdata_d;
  logic [3:0]  byteen_q, byteen_d;
  logic [1:0]  sel_q, sel_d;
  logic        addr_err, is_st, req, load;

  store_addr_check #(
    .DM_TOP (DM_TOP),
    .T0_BASE(T0_BASE),
    .T1_BASE(T1_BASE),
    .IG_BASE(IG_BASE)
  ) u_check (
    .addr_i    (A),
    .beop_i    (BEop),
    .ov_i      (DM_Ov),
    .is_write_i(1'b1),
    .addr_err_o(addr_err),
    .sel_o     (sel_d)
  );

  // Lane formatting: replicate the narrow datum across every lane it may hit
  always_comb begin
    byteen_d = 4'b0000;
    wdata_d  = Din;
    case (BEop)
      BE_SW: begin
        byteen_d = 4'b1111;
        wdata_d  = Din;
      end
      BE_SH: begin
        byteen_d = A[1] ? 4'b1100 : 4'b0011;
        wdata_d  = {Din[15:0], Din[15:0]};
      end
      BE_SB: begin
        byteen_d = 4'b0001 << A[1:0];
        wdata_d  = {4{Din[7:0]}};
      end
      default: begin
        byteen_d = 4'b0000;
        wdata_d  = Din;
      end
    endcase
  end

  // Exception, acceptance and stall; a flushed request never stalls
  always_comb begin
    is_st      = m_valid & store & (BEop != BE_RSV);
    Exc_AdES_M = is_st & addr_err;
    req        = is_st & !addr_err & !flush;
    stall_M    = req & (state_q == FULL) & !bus_ready;
    load       = req & ((state_q == EMPTY) | bus_ready);
  end

  // Write-buffer FSM with registered bus fields; fields only change on a load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= EMPTY;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      byteen_q <= 4'h0;
      sel_q    <= SEL_DM;
    end else begin
      case (state_q)
        EMPTY: if (load) state_q <= FULL;
        FULL:  if (bus_ready && !req) state_q <= EMPTY;
        default: state_q <= EMPTY;
      endcase
      if (load) begin
        addr_q   <= {A[31:2], 2'b00};
        wdata_q  <= wdata_d;
        byteen_q <= byteen_d;
        sel_q    <= sel_d;
      end
    end
  end

  assign bus_wr_valid = (state_q == FULL);
  assign bus_addr     = addr_q;
  assign bus_wdata    = wdata_q;
  assign bus_byteen   = byteen_q;
  assign bus_sel      = sel_q;

endmodule
